// File: rtl/operand_b_gen_q.sv
// ALU operand-B generator: forms the selected operand combinationally and queues
// each result, with its illegal-select flag, in a small valid/ready FIFO.
module operand_b_gen_q #(
  parameter int DW        = 16,
  parameter int IMM_A_W   = 8,
  parameter int IMM_B_W   = 12,
  parameter int INC_CONST = 2,
  parameter int SHL       = 1,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 sel,
  input  logic [DW-1:0]              reg_val,
  input  logic [IMM_A_W-1:0]         imm_a,
  input  logic [IMM_B_W-1:0]         imm_b,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] err_mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] last_data;
  logic last_err;

  logic [DW-1:0] sext_a, sext_b, zext_a, op_data;
  logic op_err;
  logic push, pop;

  assign sext_a = DW'($signed(imm_a));
  assign sext_b = DW'($signed(imm_b));
  assign zext_a = DW'(imm_a);

  always_comb begin
    op_data = '0;
    op_err  = 1'b0;
    case (sel)
      3'b000:  op_data = reg_val;
      3'b001:  op_data = DW'(INC_CONST);
      3'b010:  op_data = sext_a;
      3'b011:  op_data = zext_a;
      3'b100:  op_data = sext_a << SHL;
      3'b101:  op_data = sext_b;
      default: op_err  = 1'b1;
    endcase
  end

  // No pass-through: a full queue refuses requests even while it is being popped.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign out_data = out_valid ? data_mem[rd_ptr] : last_data;
  assign out_err  = out_valid ? err_mem[rd_ptr]  : last_err;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= op_data;
      err_mem[wr_ptr]  <= op_err;
    end
  end

  // Flush discards everything queued and wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= '0;
      last_err  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_data <= data_mem[rd_ptr];
        last_err  <= err_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_b_gen_q.sv
// Directed self-checking bench for operand_b_gen_q with default parameters (DEPTH=2).
module tb_operand_b_gen_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [15:0] reg_val;
  logic [7:0]  imm_a;
  logic [11:0] imm_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  operand_b_gen_q dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .reg_val(reg_val), .imm_a(imm_a), .imm_b(imm_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sel = 3'b000; reg_val = '0; imm_a = '0; imm_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_err, out_data, count, in_ready} !== {1'b0, 1'b0, 16'h0000, 2'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset: v=%b e=%b d=%h c=%0d rdy=%b, want 0 0 0000 0 1",
               out_valid, out_err, out_data, count, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // One push then one pop per vector; also checks latency and hold-after-pop.
  task automatic test_forms();
    logic [2:0]  v_sel  [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b001, 3'b000};
    logic [7:0]  v_ia   [6] = '{8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00};
    logic [11:0] v_ib   [6] = '{12'h000, 12'h000, 12'h000, 12'h800, 12'h000, 12'h000};
    logic [15:0] v_rv   [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234};
    logic [15:0] v_exp  [6] = '{16'hFFF0, 16'h00F0, 16'hFFE0, 16'hF800, 16'h0002, 16'h1234};
    for (int i = 0; i < 6; i++) begin
      sel = v_sel[i]; imm_a = v_ia[i]; imm_b = v_ib[i]; reg_val = v_rv[i];
      in_valid = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL form%0d_early_valid: got %b want 0", i, out_valid);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_err, out_data, count} !== {1'b1, 1'b0, v_exp[i], 2'd1}) begin
        errors++;
        $display("[TB] FAIL form%0d: v=%b e=%b d=%h c=%0d want 1 0 %h 1",
                 i, out_valid, out_err, out_data, count, v_exp[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, out_data, count} !== {1'b0, v_exp[i], 2'd0}) begin
        errors++;
        $display("[TB] FAIL form%0d_hold: v=%b d=%h c=%0d want 0 %h 0",
                 i, out_valid, out_data, count, v_exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b110; reg_val = 16'hABCD;
    tick();
    sel = 3'b000; reg_val = 16'h1234;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_err, out_data, count} !== {1'b1, 16'h0000, 2'd2}) begin
      errors++;
      $display("[TB] FAIL illegal_head: e=%b d=%h c=%0d want 1 0000 2", out_err, out_data, count);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL illegal_next: v=%b e=%b d=%h want 1 0 1234", out_valid, out_err, out_data);
    end
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'b111;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_err, out_data} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL illegal_111: e=%b d=%h want 1 0000", out_err, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; sel = 3'b000;
    in_valid = 1'b1; reg_val = 16'h0001;
    tick();
    reg_val = 16'h0002;
    tick();
    reg_val = 16'h0003;
    checks++;
    if ({in_ready, count} !== {1'b0, 2'd2}) begin
      errors++;
      $display("[TB] FAIL full_stall: rdy=%b c=%0d want 0 2", in_ready, count);
    end
    tick();
    checks++;
    if ({count, out_data} !== {2'd2, 16'h0001}) begin
      errors++;
      $display("[TB] FAIL stall_hold: c=%0d d=%h want 2 0001", count, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({count, out_data, in_ready} !== {2'd1, 16'h0002, 1'b1}) begin
      errors++;
      $display("[TB] FAIL full_pop_only: c=%0d d=%h rdy=%b want 1 0002 1", count, out_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({count, out_data} !== {2'd1, 16'h0003}) begin
      errors++;
      $display("[TB] FAIL push_pop: c=%0d d=%h want 1 0003", count, out_data);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, count, out_data} !== {1'b0, 2'd0, 16'h0003}) begin
      errors++;
      $display("[TB] FAIL drain: v=%b c=%0d d=%h want 0 0 0003", out_valid, count, out_data);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; sel = 3'b000;
    in_valid = 1'b1; reg_val = 16'h00AA;
    tick();
    reg_val = 16'h00BB;
    tick();
    flush = 1'b1;
    tick();
    checks++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL flush_full: v=%b c=%0d want 0 0", out_valid, count);
    end
    flush = 1'b0;
    reg_val = 16'h00CC;
    tick();
    in_valid = 1'b1; flush = 1'b1; reg_val = 16'h00DD;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    tick();
    checks++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL flush_push: v=%b c=%0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sel = 3'b000;
    in_valid = 1'b1; reg_val = 16'h5555;
    tick();
    reg_val = 16'h6666;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_err, out_data, count} !== {1'b0, 1'b0, 16'h0000, 2'd0}) begin
      errors++;
      $display("[TB] FAIL reset_mid: v=%b e=%b d=%h c=%0d want 0 0 0000 0",
               out_valid, out_err, out_data, count);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if ({out_valid, count, in_ready} !== {1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL after_reset: v=%b c=%0d rdy=%b want 0 0 1", out_valid, count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_forms();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
